// File: rtl/load_store_unit.sv
// Load/store unit: data-memory initiator for RV32I loads and stores.
// It decodes funct3 into a byte mask and lane-replicated write data,
// drives the word-addressed memory port, and returns an extended load result or an error code.

`ifndef MEM_CMD_READ
`define MEM_CMD_READ 1'b0
`endif
`ifndef MEM_CMD_WRITE
`define MEM_CMD_WRITE 1'b1
`endif

module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_store_data,
    output logic        resp_valid,
    output logic [31:0] resp_load_data,
    output logic [1:0]  resp_error,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_mask,
    output logic        mem_enable,
    output logic        mem_cmd,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_load_data,
    input  logic        mem_valid
);

    localparam logic [1:0] ERR_OK        = 2'b00;
    localparam logic [1:0] ERR_MISALIGN  = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL   = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT   = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc_c;
    logic [1:0]         lane_q, lane_d;
    logic [2:0]         funct3_q, funct3_d;
    logic               is_store_q, is_store_d;

    logic               req_ready_d, resp_valid_d, mem_enable_d, mem_cmd_d;
    logic [31:0]        resp_load_data_d, mem_addr_d, mem_write_data_d;
    logic [1:0]         resp_error_d;
    logic [3:0]         mem_mask_d;

    logic               req_illegal_c, req_misaligned_c;
    logic [3:0]         req_mask_c;
    logic [31:0]        req_wdata_c, load_shift_c, load_ext_c;

    // Classify the incoming request and build its byte mask and replicated store data.
    always_comb begin
        req_illegal_c = 1'b1;
        unique case (req_funct3)
            3'b000, 3'b001, 3'b010: req_illegal_c = 1'b0;
            3'b100, 3'b101:         req_illegal_c = req_is_store;
            default:                req_illegal_c = 1'b1;
        endcase
        req_misaligned_c = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                           ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        unique case (req_funct3[1:0])
            2'b00: begin
                req_mask_c  = 4'(4'b0001 << req_addr[1:0]);
                req_wdata_c = {4{req_store_data[7:0]}};
            end
            2'b01: begin
                req_mask_c  = 4'(4'b0011 << req_addr[1:0]);
                req_wdata_c = {2{req_store_data[15:0]}};
            end
            default: begin
                req_mask_c  = 4'b1111;
                req_wdata_c = req_store_data;
            end
        endcase
    end

    // Shift the returned word down to the addressed lane and extend per funct3.
    always_comb begin
        load_shift_c = mem_load_data >> {lane_q, 3'b000};
        unique case (funct3_q)
            3'b000:  load_ext_c = {{24{load_shift_c[7]}}, load_shift_c[7:0]};
            3'b100:  load_ext_c = {24'h0, load_shift_c[7:0]};
            3'b001:  load_ext_c = {{16{load_shift_c[15]}}, load_shift_c[15:0]};
            3'b101:  load_ext_c = {16'h0, load_shift_c[15:0]};
            default: load_ext_c = load_shift_c;
        endcase
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        lane_d           = lane_q;
        funct3_d         = funct3_q;
        is_store_d       = is_store_q;
        resp_load_data_d = resp_load_data;
        resp_error_d     = resp_error;
        mem_addr_d       = mem_addr;
        mem_mask_d       = mem_mask;
        mem_cmd_d        = mem_cmd;
        mem_write_data_d = mem_write_data;
        cnt_inc_c        = cnt_q + CNT_W'(1);

        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    funct3_d   = req_funct3;
                    is_store_d = req_is_store;
                    lane_d     = req_addr[1:0];
                    if (req_illegal_c) begin
                        state_d          = S_RESP;
                        resp_error_d     = ERR_ILLEGAL;
                        resp_load_data_d = '0;
                    end else if (req_misaligned_c) begin
                        state_d          = S_RESP;
                        resp_error_d     = ERR_MISALIGN;
                        resp_load_data_d = '0;
                    end else begin
                        state_d          = S_ACCESS;
                        mem_addr_d       = {req_addr[31:2], 2'b00};
                        mem_mask_d       = req_mask_c;
                        mem_cmd_d        = req_is_store ? `MEM_CMD_WRITE : `MEM_CMD_READ;
                        mem_write_data_d = req_wdata_c;
                    end
                end
            end
            S_ACCESS: begin
                if (is_store_q) begin
                    state_d          = S_RESP;
                    resp_error_d     = ERR_OK;
                    resp_load_data_d = '0;
                end else if (mem_valid) begin
                    state_d          = S_RESP;
                    resp_error_d     = ERR_OK;
                    resp_load_data_d = load_ext_c;
                end else begin
                    cnt_d = cnt_inc_c;
                    if (cnt_inc_c == CNT_W'(TIMEOUT_CYCLES)) begin
                        state_d          = S_RESP;
                        resp_error_d     = ERR_TIMEOUT;
                        resp_load_data_d = '0;
                    end
                end
            end
            S_RESP: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        req_ready_d  = (state_d == S_IDLE);
        resp_valid_d = (state_d == S_RESP);
        mem_enable_d = (state_d == S_ACCESS);
    end

    // State, latched request fields and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            lane_q         <= '0;
            funct3_q       <= '0;
            is_store_q     <= 1'b0;
            req_ready      <= 1'b0;
            resp_valid     <= 1'b0;
            resp_load_data <= '0;
            resp_error     <= ERR_OK;
            mem_addr       <= '0;
            mem_mask       <= '0;
            mem_enable     <= 1'b0;
            mem_cmd        <= `MEM_CMD_READ;
            mem_write_data <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            lane_q         <= lane_d;
            funct3_q       <= funct3_d;
            is_store_q     <= is_store_d;
            req_ready      <= req_ready_d;
            resp_valid     <= resp_valid_d;
            resp_load_data <= resp_load_data_d;
            resp_error     <= resp_error_d;
            mem_addr       <= mem_addr_d;
            mem_mask       <= mem_mask_d;
            mem_enable     <= mem_enable_d;
            mem_cmd        <= mem_cmd_d;
            mem_write_data <= mem_write_data_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small byte-masked word memory model.
`timescale 1ns/1ps

module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_store_data;
    logic        resp_valid;
    logic [31:0] resp_load_data;
    logic [1:0]  resp_error;
    logic [31:0] mem_addr, mem_write_data, mem_load_data;
    logic [3:0]  mem_mask;
    logic        mem_enable, mem_cmd, mem_valid;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:255];
    logic        stall;

    // Captured results of the last request.
    logic        r_ready, r_en, r_cmd, r_done;
    logic [3:0]  r_mask;
    logic [31:0] r_addr, r_wdata, r_data;
    logic [1:0]  r_err;
    int          r_lat, r_acc;

    load_store_unit #(.TIMEOUT_CYCLES(16), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_store_data(req_store_data),
        .resp_valid(resp_valid), .resp_load_data(resp_load_data), .resp_error(resp_error),
        .mem_addr(mem_addr), .mem_mask(mem_mask), .mem_enable(mem_enable), .mem_cmd(mem_cmd),
        .mem_write_data(mem_write_data), .mem_load_data(mem_load_data), .mem_valid(mem_valid)
    );

    always #5 clk = ~clk;

    assign mem_load_data = mem[mem_addr[9:2]];
    assign mem_valid     = mem_enable && (mem_cmd == 1'b0) && !stall;

    // Memory model: byte-masked write on each enabled write cycle.
    always @(posedge clk) begin
        if (mem_enable && mem_cmd) begin
            for (int b = 0; b < 4; b++)
                if (mem_mask[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_write_data[8*b +: 8];
        end
    end

    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        r_ready        = req_ready;
        req_valid      = 1'b1;
        req_is_store   = st;
        req_funct3     = f3;
        req_addr       = a;
        req_store_data = d;
        @(posedge clk);
        #1 req_valid = 1'b0;
        r_lat = 0; r_acc = 0; r_en = 1'b0; r_done = 1'b0;
        r_mask = '0; r_addr = '0; r_wdata = '0; r_cmd = 1'b0; r_data = '0; r_err = '0;
        for (int n = 0; n < 200 && !r_done; n++) begin
            @(negedge clk);
            r_lat++;
            if (mem_enable) begin
                r_acc++; r_en = 1'b1;
                r_mask = mem_mask; r_addr = mem_addr; r_wdata = mem_write_data; r_cmd = mem_cmd;
            end
            if (resp_valid) begin
                r_data = resp_load_data; r_err = resp_error; r_done = 1'b1;
            end
        end
        if (!r_done) begin
            checks++; errors++;
            $display("FAIL resp_wait: no resp_valid within 200 cycles for addr %h", a);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'b0;
        req_addr = '0; req_store_data = '0; stall = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", req_ready); end
        checks++; if ({resp_valid, mem_enable, mem_cmd} !== 3'b000) begin errors++; $display("FAIL rst_ctrl got %b exp 000", {resp_valid, mem_enable, mem_cmd}); end
        checks++; if ({mem_addr, mem_write_data, resp_load_data} !== 96'h0) begin errors++; $display("FAIL rst_data got %h exp 0", {mem_addr, mem_write_data, resp_load_data}); end
        checks++; if ({mem_mask, resp_error} !== 6'b0) begin errors++; $display("FAIL rst_mask_err got %b exp 0", {mem_mask, resp_error}); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b exp 1", req_ready); end
    endtask

    task automatic test_store_word;
        do_req(1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
        checks++; if (r_ready !== 1'b1) begin errors++; $display("FAIL sw_ready got %b exp 1", r_ready); end
        checks++; if (r_lat !== 2) begin errors++; $display("FAIL sw_latency got %0d exp 2", r_lat); end
        checks++; if (r_acc !== 1) begin errors++; $display("FAIL sw_access_cycles got %0d exp 1", r_acc); end
        checks++; if ({r_mask, r_cmd} !== 5'b11111) begin errors++; $display("FAIL sw_mask_cmd got %b exp 11111", {r_mask, r_cmd}); end
        checks++; if (r_addr !== 32'h100 || r_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_addr_data got %h %h exp 100 deadbeef", r_addr, r_wdata); end
        checks++; if (r_err !== 2'b00 || r_data !== 32'h0) begin errors++; $display("FAIL sw_resp got %b %h exp 00 0", r_err, r_data); end
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL sw_resp_pulse got %b exp 0", resp_valid); end
    endtask

    task automatic test_store_byte;
        do_req(1'b1, 3'b000, 32'h103, 32'h000000A5);
        checks++; if (r_mask !== 4'b1000 || r_wdata !== 32'hA5A5A5A5 || r_addr !== 32'h100) begin errors++; $display("FAIL sb_port got %b %h %h exp 1000 a5a5a5a5 100", r_mask, r_wdata, r_addr); end
        do_req(1'b0, 3'b100, 32'h103, 32'h0);
        checks++; if (r_data !== 32'h000000A5 || r_mask !== 4'b1000 || r_cmd !== 1'b0) begin errors++; $display("FAIL lbu got %h %b %b exp 000000a5 1000 0", r_data, r_mask, r_cmd); end
        checks++; if (r_lat !== 2) begin errors++; $display("FAIL lbu_latency got %0d exp 2", r_lat); end
        do_req(1'b0, 3'b000, 32'h103, 32'h0);
        checks++; if (r_data !== 32'hFFFFFFA5) begin errors++; $display("FAIL lb got %h exp ffffffa5", r_data); end
        do_req(1'b0, 3'b010, 32'h100, 32'h0);
        checks++; if (r_data !== 32'hA5ADBEEF) begin errors++; $display("FAIL lw_after_sb got %h exp a5adbeef", r_data); end
    endtask

    task automatic test_half;
        do_req(1'b1, 3'b010, 32'h100, 32'h80017FFF);
        do_req(1'b0, 3'b001, 32'h102, 32'h0);
        checks++; if (r_data !== 32'hFFFF8001 || r_mask !== 4'b1100) begin errors++; $display("FAIL lh got %h %b exp ffff8001 1100", r_data, r_mask); end
        do_req(1'b0, 3'b101, 32'h102, 32'h0);
        checks++; if (r_data !== 32'h00008001) begin errors++; $display("FAIL lhu got %h exp 00008001", r_data); end
        do_req(1'b0, 3'b001, 32'h100, 32'h0);
        checks++; if (r_data !== 32'h00007FFF || r_mask !== 4'b0011) begin errors++; $display("FAIL lh_low got %h %b exp 00007fff 0011", r_data, r_mask); end
        do_req(1'b0, 3'b010, 32'h100, 32'h0);
        checks++; if (r_data !== 32'h80017FFF || r_err !== 2'b00) begin errors++; $display("FAIL lw got %h %b exp 80017fff 00", r_data, r_err); end
        do_req(1'b1, 3'b001, 32'h202, 32'hCAFE1234);
        checks++; if (r_mask !== 4'b1100 || r_wdata !== 32'h12341234 || r_addr !== 32'h200) begin errors++; $display("FAIL sh_port got %b %h %h exp 1100 12341234 200", r_mask, r_wdata, r_addr); end
        do_req(1'b0, 3'b010, 32'h200, 32'h0);
        checks++; if (r_data !== 32'h12340000) begin errors++; $display("FAIL lw_after_sh got %h exp 12340000", r_data); end
    endtask

    task automatic test_errors;
        do_req(1'b0, 3'b010, 32'h101, 32'h0);
        checks++; if (r_err !== 2'b01 || r_lat !== 1 || r_en !== 1'b0 || r_data !== 32'h0) begin errors++; $display("FAIL lw_misalign got err %b lat %0d en %b data %h exp 01 1 0 0", r_err, r_lat, r_en, r_data); end
        do_req(1'b1, 3'b001, 32'h203, 32'h0);
        checks++; if (r_err !== 2'b01 || r_lat !== 1 || r_en !== 1'b0) begin errors++; $display("FAIL sh_misalign got err %b lat %0d en %b exp 01 1 0", r_err, r_lat, r_en); end
        do_req(1'b0, 3'b011, 32'h100, 32'h0);
        checks++; if (r_err !== 2'b10 || r_lat !== 1 || r_en !== 1'b0) begin errors++; $display("FAIL ld_illegal got err %b lat %0d en %b exp 10 1 0", r_err, r_lat, r_en); end
        do_req(1'b1, 3'b100, 32'h100, 32'h0);
        checks++; if (r_err !== 2'b10 || r_en !== 1'b0) begin errors++; $display("FAIL st_illegal got err %b en %b exp 10 0", r_err, r_en); end
        do_req(1'b0, 3'b111, 32'h101, 32'h0);
        checks++; if (r_err !== 2'b10) begin errors++; $display("FAIL err_priority got %b exp 10", r_err); end
        do_req(1'b0, 3'b001, 32'h103, 32'h0);
        checks++; if (r_err !== 2'b01) begin errors++; $display("FAIL lh_misalign got %b exp 01", r_err); end
    endtask

    task automatic test_timeout;
        stall = 1'b1;
        do_req(1'b0, 3'b010, 32'h100, 32'h0);
        checks++; if (r_acc !== 16) begin errors++; $display("FAIL to_access_cycles got %0d exp 16", r_acc); end
        checks++; if (r_lat !== 17 || r_err !== 2'b11 || r_data !== 32'h0) begin errors++; $display("FAIL to_resp got lat %0d err %b data %h exp 17 11 0", r_lat, r_err, r_data); end
        stall = 1'b0;
        do_req(1'b0, 3'b010, 32'h100, 32'h0);
        checks++; if (r_ready !== 1'b1 || r_data !== 32'h80017FFF || r_err !== 2'b00 || r_lat !== 2) begin errors++; $display("FAIL to_next got rdy %b data %h err %b lat %0d exp 1 80017fff 00 2", r_ready, r_data, r_err, r_lat); end
    endtask

    task automatic test_reset_mid_access;
        logic seen_resp;
        stall = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (mem_enable !== 1'b1) begin errors++; $display("FAIL mid_enable got %b exp 1", mem_enable); end
        #2 reset = 1'b0;
        #1;
        checks++; if (mem_enable !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL mid_async_drop got en %b rdy %b exp 0 0", mem_enable, req_ready); end
        seen_resp = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            if (resp_valid) seen_resp = 1'b1;
        end
        stall = 1'b0;
        reset = 1'b1;
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            if (resp_valid) seen_resp = 1'b1;
        end
        checks++; if (seen_resp !== 1'b0) begin errors++; $display("FAIL mid_no_resp got %b exp 0", seen_resp); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %b exp 1", req_ready); end
        do_req(1'b0, 3'b010, 32'h100, 32'h0);
        checks++; if (r_data !== 32'h80017FFF || r_err !== 2'b00 || r_lat !== 2) begin errors++; $display("FAIL mid_next_lw got %h %b lat %0d exp 80017fff 00 2", r_data, r_err, r_lat); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        test_reset();
        test_store_word();
        test_store_byte();
        test_half();
        test_errors();
        test_timeout();
        test_reset_mid_access();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
